verifier_adder_tree_arb: RTL
============================

# verifier_adder_tree_arb

Round-robin arbiter and sequencer that time-shares one verifier adder tree among `nreq` requesters, e.g. the V(0), V(1) and V(2) evaluation paths of a sumcheck round. It latches per-requester start pulses and selects one requester at a time, steering that requester's `ngates` partial values onto the tree inputs. It produces the rising-edge enable the tree requires, waits for the tree's completion pulse, then returns the sum with a per-requester done pulse. It sits between the per-gate prover datapath and a single `verifier_adder_tree` instance.

## Interface
- `ngates`, 8: number of partial values per requester; must match the tree.
- `nreq`, 3: number of requesters, 2..8.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `req` in `nreq`: one-cycle start pulse per requester.
- `parts` in `nreq`×`ngates`×`F_NBITS`: per-requester partial values. Requester i holds them stable from its `req` pulse until its `done` pulse.
- `flush` in 1: synchronous clear of all pending requests that have not yet been granted.
- `tree_en` out 1: enable to the tree. The tree starts on a 0→1 edge.
- `tree_parts` out `ngates`×`F_NBITS`: the granted requester's `parts`.
- `tree_ready_pulse` in 1: the tree's one-cycle completion pulse.
- `tree_v` in `F_NBITS`: the tree's sum output.
- `done` out `nreq`: one-cycle completion pulse, one-hot.
- `result` out `F_NBITS`: registered sum, held until the next completion.
- `result_id` out `$clog2(nreq)`: index of the requester that owns `result`.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `req_err` out 1: one-cycle pulse when a `req` arrives for an index that is already pending or granted.

## Operation
- Pending vector `pend[nreq]`:
  - `req[i]` sets `pend[i]`.
  - Exiting DONE clears the granted bit.
  - If `req[i]` arrives in the same cycle that bit i is cleared, the bit ends set: set wins over clear, and the new request is queued.
- Redundant request: `req[i]` while `pend[i]` is set (and bit i is not being cleared that cycle) pulses `req_err` and is otherwise ignored.
- `flush` clears every pending bit except the granted one. A `req` in the same cycle as `flush` wins (the bit ends set). An in-flight operation always completes.
- Arbitration is round-robin. Search starts at `last+1` mod `nreq`, where `last` is the most recently granted index. After reset `last = nreq-1`, so index 0 has first priority.
- FSM states:
  - IDLE: `tree_en=0`. If any `pend` bit is set, register the grant index `g` and go to LAUNCH.
  - LAUNCH: `tree_en=1`, one cycle; the tree samples `tree_parts` here. Go to BUSY.
  - BUSY: `tree_en=1`. On `tree_ready_pulse`, capture `tree_v` into `result`, set `result_id=g` and go to DONE. Any `tree_ready_pulse` seen in LAUNCH is ignored.
  - DONE: `tree_en=0`, `done[g]=1` for one cycle, clear `pend[g]`, set `last=g`, go to IDLE.
- `tree_parts = parts[g]` in every state. `g` changes only on IDLE→LAUNCH. `tree_en` is a direct register output.
- No arithmetic is performed; values pass through unmodified at `F_NBITS`.

## Timing
- Reset values:
  - FSM = IDLE; `tree_en=0`, `done=0`, `req_err=0`, `busy=0`.
  - `result=0`, `result_id=0`, `pend=0`, `g=0`, `last=nreq-1`.
- A `req` at edge t is visible in `pend` at t+1. With the FSM already in IDLE, the sequence is IDLE at t+1, LAUNCH at t+2 (`tree_en` rises), then BUSY.
- `tree_ready_pulse` at cycle b → `done` and `result` valid at b+1, IDLE at b+2.
- `tree_en` is low for at least 2 cycles (DONE then IDLE) between operations, which guarantees a fresh rising edge for the tree.
- Throughput: one operation per (tree latency + 4) cycles.
- `rst` mid-operation forces all outputs to their reset values immediately. The tree is reset by the same reset net.

## Test plan
- Single request (`ngates=8`, `parts[1]=1..8`): pulse `req[1]` → `tree_en` rises 2 cycles later; `done=3'b010`, `result=36`, `result_id=1`.
- Simultaneous `req=3'b111` → grants in order 0, 1, 2. Each `done` carries its own sum: 8, 16, 24 for all-ones, all-twos and all-threes parts. `tree_en` is low ≥2 cycles between grants.
- Fairness: hold requester 0 re-requesting on every `done[0]` while `req[2]` is pending → grant order 0, 2, 0 (requester 2 never starves).
- Redundant `req[1]` while `pend[1]` is set → `req_err` pulses once; exactly one `done[1]` follows.
- `req[0]` in the same cycle as `done[0]` → a second operation for index 0 runs, with no `req_err`.
- `flush` while 0 is busy and 1, 2 are pending → only `done[0]` occurs, then `busy` drops. Assert `rst` during BUSY → all outputs return to reset values the same cycle.

Source files
------------

// File: rtl/verifier_adder_tree_arb.sv
// ============================================================================
// Module  : verifier_adder_tree_arb
// Brief   : Round-robin arbiter/sequencer sharing one verifier adder tree
//           among NREQ requesters; launches the tree, returns per-requester sums.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module verifier_adder_tree_arb #(
  parameter int NGATES  = 8,
  parameter int NREQ    = 3,
  parameter int F_NBITS = 32
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NREQ-1:0]                            req,
  input  logic [NREQ*NGATES*F_NBITS-1:0]             parts,
  input  logic                                       flush,
  output logic                                       tree_en,
  output logic [NGATES*F_NBITS-1:0]                  tree_parts,
  input  logic                                       tree_ready_pulse,
  input  logic [F_NBITS-1:0]                         tree_v,
  output logic [NREQ-1:0]                            done,
  output logic [F_NBITS-1:0]                         result,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] result_id,
  output logic                                       busy,
  output logic                                       req_err
);

  localparam int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SLOT_W = NGATES * F_NBITS;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_BUSY   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]      r_state;
  logic [NREQ-1:0] r_pend;
  logic [ID_W-1:0] r_g;
  logic [ID_W-1:0] r_last;

  logic            w_found;
  logic [ID_W-1:0] w_next_g;
  logic [NREQ-1:0] w_g_oh;
  logic [NREQ-1:0] w_clr;
  logic [NREQ-1:0] w_own;
  logic [NREQ-1:0] w_flush_clr;
  logic [NREQ-1:0] w_pend_nxt;
  logic            w_err;

  // Round-robin search starting just after the most recent grant.
  always_comb begin
    w_found  = 1'b0;
    w_next_g = r_g;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = int'(r_last) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_found && r_pend[idx]) begin
        w_found  = 1'b1;
        w_next_g = ID_W'(idx);
      end
    end
  end

  assign w_g_oh = NREQ'(1) << r_g;
  assign w_clr  = (r_state == S_DONE) ? w_g_oh : '0;

  // The bit being granted this cycle (or already granted) survives a flush.
  assign w_own       = (r_state == S_IDLE) ? (w_found ? (NREQ'(1) << w_next_g) : '0) : w_g_oh;
  assign w_flush_clr = flush ? ~w_own : '0;
  assign w_pend_nxt  = (r_pend & ~w_clr & ~w_flush_clr) | req;
  assign w_err       = |(req & r_pend & ~w_clr);

  assign tree_parts = parts[int'(r_g)*SLOT_W +: SLOT_W];
  assign busy       = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pend    <= '0;
      r_g       <= '0;
      r_last    <= ID_W'(NREQ - 1);
      tree_en   <= 1'b0;
      done      <= '0;
      req_err   <= 1'b0;
      result    <= '0;
      result_id <= '0;
    end else begin
      r_pend  <= w_pend_nxt;
      req_err <= w_err;
      done    <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_g     <= w_next_g;
            tree_en <= 1'b1;
            r_state <= S_LAUNCH;
          end
        end
        S_LAUNCH: r_state <= S_BUSY;
        S_BUSY: begin
          if (tree_ready_pulse) begin
            result    <= tree_v;
            result_id <= r_g;
            done      <= w_g_oh;
            tree_en   <= 1'b0;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_last  <= r_g;
          r_state <= S_IDLE;
        end
        default: begin
          tree_en <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
